mod_ctr_checker: RTL and testbench

//   Receive-side monitor for a modulo-N free-running counter (e.g. the 2-bit

---
 rtl/mod_ctr_checker.sv | 133 +++++++++++++
 tb/tb_mod_ctr_checker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mod_ctr_checker.sv
// Receive-side monitor for a modulo-MODULUS counter stream: predicts each next
// value, locks after a run of correct transitions, and counts sequence errors.
module mod_ctr_checker #(
  parameter int WIDTH      = 2,
  parameter int MODULUS    = 3,
  parameter int LOCK_CNT   = 2,
  parameter int UNLOCK_CNT = 2,
  parameter int ERRW       = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_Valid,
  input  logic [WIDTH-1:0] In_Cnt,
  input  logic             Ctr_Reset,
  input  logic             Clr_Err,
  output logic             Locked,
  output logic             Err,
  output logic [ERRW-1:0]  Err_Count,
  output logic [WIDTH-1:0] Expected,
  output logic [0:0]       dbg_state
);

  // Beat handshake: In_Cnt and Ctr_Reset are consumed on every rising Clk
  // edge where In_Valid is high; there is no back-pressure (always ready).

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);
  localparam logic [GW-1:0]    LOCK_TGT   = GW'(LOCK_CNT);
  localparam logic [BW-1:0]    UNLOCK_TGT = BW'(UNLOCK_CNT);

  logic [0:0]       state, state_n;
  logic             seeded, seeded_n;
  logic [GW-1:0]    good_run, good_n;
  logic [BW-1:0]    bad_run, bad_n;
  logic [WIDTH-1:0] exp_n;
  logic             err_n;
  logic [ERRW-1:0]  cnt_n;
  logic             in_range;
  logic             match;

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] v);
    if (v == MAXV) return '0;
    else           return v + 1'b1;
  endfunction

  assign in_range = ({1'b0, In_Cnt} < MOD_W);
  assign match    = in_range && (In_Cnt == Expected);

  always_comb begin
    state_n  = state;
    seeded_n = seeded;
    good_n   = good_run;
    bad_n    = bad_run;
    exp_n    = Expected;
    err_n    = 1'b0;
    if (In_Valid) begin
      if (state == HUNT) begin
        if (!in_range) begin
          seeded_n = 1'b0;
          good_n   = '0;
        end else if (seeded && match) begin
          exp_n = nxt(In_Cnt);
          if (good_run + 1'b1 == LOCK_TGT) begin
            state_n = LOCKED;
            good_n  = '0;
            bad_n   = '0;
          end else begin
            good_n = good_run + 1'b1;
          end
        end else begin
          seeded_n = 1'b1;
          exp_n    = nxt(In_Cnt);
          good_n   = '0;
        end
      end else begin
        if (match) begin
          bad_n = '0;
          exp_n = nxt(In_Cnt);
        end else begin
          // Flywheel: keep predicting from our own sequence so a single
          // glitch costs exactly one error.
          err_n = 1'b1;
          exp_n = nxt(Expected);
          if (bad_run + 1'b1 == UNLOCK_TGT) begin
            state_n  = HUNT;
            bad_n    = '0;
            good_n   = '0;
            seeded_n = in_range;
            if (in_range) exp_n = nxt(In_Cnt);
          end else begin
            bad_n = bad_run + 1'b1;
          end
        end
      end
      if (Ctr_Reset) exp_n = '0;
    end
  end

  always_comb begin
    cnt_n = Err_Count;
    if (Clr_Err)                   cnt_n = err_n ? ERRW'(1) : '0;
    else if (err_n && !(&Err_Count)) cnt_n = Err_Count + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= HUNT;
      seeded    <= 1'b0;
      good_run  <= '0;
      bad_run   <= '0;
      Expected  <= '0;
      Err       <= 1'b0;
      Err_Count <= '0;
    end else begin
      state     <= state_n;
      seeded    <= seeded_n;
      good_run  <= good_n;
      bad_run   <= bad_n;
      Expected  <= exp_n;
      Err       <= err_n;
      Err_Count <= cnt_n;
    end
  end

  assign Locked    = (state == LOCKED);
  assign dbg_state = state;

endmodule

// File: tb/tb_mod_ctr_checker.sv
// Directed bench for mod_ctr_checker: a vector table walks lock, glitch, unlock,
// Ctr_Reset, gaps and Reset; hand sequences cover saturation and Clr_Err.
module tb_mod_ctr_checker;
  localparam int WIDTH = 2;
  localparam int ERRW  = 8;
  localparam int OW    = 2 + ERRW + WIDTH;
  localparam int NV    = 33;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             In_Valid = 1'b0;
  logic [WIDTH-1:0] In_Cnt = '0;
  logic             Ctr_Reset = 1'b0;
  logic             Clr_Err = 1'b0;
  logic             Locked;
  logic             Err;
  logic [ERRW-1:0]  Err_Count;
  logic [WIDTH-1:0] Expected;
  logic [0:0]       dbg_state;

  mod_ctr_checker dut (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Cnt(In_Cnt),
    .Ctr_Reset(Ctr_Reset), .Clr_Err(Clr_Err), .Locked(Locked), .Err(Err),
    .Err_Count(Err_Count), .Expected(Expected), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  typedef struct {
    logic             rst;
    logic             v;
    logic [WIDTH-1:0] cnt;
    logic             cr;
    logic             clr;
    logic             lk;
    logic             er;
    logic [ERRW-1:0]  ec;
    logic [WIDTH-1:0] ex;
  } vec_t;

  vec_t vecs[NV];
  logic [OW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t mk(logic rst, logic v, logic [WIDTH-1:0] cnt, logic cr,
                              logic clr, logic lk, logic er, int ec, logic [WIDTH-1:0] ex);
    vec_t t;
    t.rst = rst; t.v = v; t.cnt = cnt; t.cr = cr; t.clr = clr;
    t.lk = lk; t.er = er; t.ec = ERRW'(ec); t.ex = ex;
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] model_next(logic [WIDTH-1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // driver
  task automatic drive(logic rst, logic v, logic [WIDTH-1:0] cnt, logic cr, logic clr);
    Reset = rst; In_Valid = v; Ctr_Reset = cr; Clr_Err = clr;
    In_Cnt = v ? cnt : WIDTH'($urandom_range(0, 3));
    @(posedge Clk);
    #1;
  endtask

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // scoreboard: expected outputs are queued before the edge and retired after it
  task automatic score(string tag);
    logic [OW-1:0] e;
    e = exp_q.pop_front();
    check({tag, ".locked"},    int'(Locked),    int'(e[OW-1]));
    check({tag, ".dbg_state"}, int'(dbg_state), int'(e[OW-1]));
    check({tag, ".err"},       int'(Err),       int'(e[OW-2]));
    check({tag, ".err_count"}, int'(Err_Count), int'(e[WIDTH +: ERRW]));
    check({tag, ".expected"},  int'(Expected),  int'(e[WIDTH-1:0]));
  endtask

  task automatic step(logic rst, logic v, logic [WIDTH-1:0] cnt, logic cr, logic clr,
                      logic lk, logic er, int ec, logic [WIDTH-1:0] ex, string tag);
    exp_q.push_back({lk, er, ERRW'(ec), ex});
    drive(rst, v, cnt, cr, clr);
    score(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] m_exp;
    int errs;
    //             rst v  cnt cr clr  lk er ec ex
    vecs[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0);  // reset state
    vecs[1]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 1);  // seed
    vecs[2]  = mk(0, 1, 1, 0, 0,  0, 0, 0, 2);
    vecs[3]  = mk(0, 1, 2, 0, 0,  1, 0, 0, 0);  // second good transition locks
    vecs[4]  = mk(0, 1, 0, 0, 0,  1, 0, 0, 1);
    vecs[5]  = mk(0, 1, 1, 0, 0,  1, 0, 0, 2);
    vecs[6]  = mk(0, 1, 2, 0, 0,  1, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 0,  1, 0, 0, 1);
    vecs[8]  = mk(0, 1, 1, 0, 0,  1, 0, 0, 2);
    vecs[9]  = mk(0, 1, 3, 0, 0,  1, 1, 1, 0);  // single glitch, flywheel
    vecs[10] = mk(0, 1, 0, 0, 0,  1, 0, 1, 1);
    vecs[11] = mk(0, 1, 1, 0, 0,  1, 0, 1, 2);
    vecs[12] = mk(0, 0, 0, 0, 0,  1, 0, 1, 2);  // gap: hold
    vecs[13] = mk(0, 0, 0, 0, 0,  1, 0, 1, 2);
    vecs[14] = mk(0, 1, 2, 0, 0,  1, 0, 1, 0);
    vecs[15] = mk(0, 1, 0, 0, 1,  1, 0, 0, 1);  // clear count
    vecs[16] = mk(0, 1, 1, 0, 0,  1, 0, 0, 2);
    vecs[17] = mk(0, 1, 1, 0, 0,  1, 1, 1, 0);  // mismatch 1
    vecs[18] = mk(0, 1, 1, 0, 0,  0, 1, 2, 2);  // mismatch 2 -> HUNT, reseed from 1
    vecs[19] = mk(0, 1, 2, 0, 0,  0, 0, 2, 0);
    vecs[20] = mk(0, 1, 0, 0, 0,  1, 0, 2, 1);
    vecs[21] = mk(0, 1, 1, 1, 0,  1, 0, 2, 0);  // Ctr_Reset forces Expected=0
    vecs[22] = mk(0, 1, 0, 0, 0,  1, 0, 2, 1);
    vecs[23] = mk(1, 1, 1, 0, 0,  0, 0, 0, 0);  // Reset mid-LOCKED
    vecs[24] = mk(0, 0, 2, 0, 0,  0, 0, 0, 0);
    vecs[25] = mk(0, 1, 3, 0, 0,  0, 0, 0, 0);  // out-of-range in HUNT: no error
    vecs[26] = mk(0, 1, 2, 0, 0,  0, 0, 0, 0);  // seed at wrap
    vecs[27] = mk(0, 1, 1, 0, 0,  0, 0, 0, 2);  // mismatch in HUNT reseeds
    vecs[28] = mk(0, 1, 2, 0, 0,  0, 0, 0, 0);
    vecs[29] = mk(0, 1, 0, 0, 0,  1, 0, 0, 1);
    vecs[30] = mk(0, 1, 3, 0, 0,  1, 1, 1, 2);
    vecs[31] = mk(0, 1, 3, 0, 0,  0, 1, 2, 0);  // unlock on out-of-range: unseeded
    vecs[32] = mk(0, 1, 0, 0, 0,  0, 0, 2, 1);  // reseed

    for (int i = 0; i < NV; i++)
      step(vecs[i].rst, vecs[i].v, vecs[i].cnt, vecs[i].cr, vecs[i].clr,
           vecs[i].lk, vecs[i].er, int'(vecs[i].ec), vecs[i].ex, $sformatf("v%0d", i));

    // relock, then alternate glitch / good beat to force 300 errors
    step(0, 1, 1, 0, 0, 0, 0, 2, 2, "relock_a");
    step(0, 1, 2, 0, 0, 1, 0, 2, 0, "relock_b");
    m_exp = 2'd0;
    errs = 0;
    while (errs < 300) begin
      drive(0, 1, 2'd3, 0, 0);
      m_exp = model_next(m_exp);
      errs++;
      check($sformatf("sat_err%0d", errs), int'(Err), 1);
      drive(0, 1, m_exp, 0, 0);
      m_exp = model_next(m_exp);
    end
    check("sat_count",    int'(Err_Count), 255);
    check("sat_locked",   int'(Locked),    1);
    check("sat_expected", int'(Expected),  int'(m_exp));

    step(0, 0, 0, 0, 1, 1, 0, 0, m_exp, "clr_idle");
    step(0, 1, 3, 0, 1, 1, 1, 1, model_next(m_exp), "clr_with_err");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
